// File: rtl/led_pwm_driver.sv
// LED PWM driver: turns an 8-bit brightness level into a glitch-free PWM
// waveform shared by all LED channels. A new level is buffered one deep and
// only takes effect at a period boundary, so no period is ever cut short or
// stretched. Each channel can be individually forced low through chan_mask.

module led_pwm_driver #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 98
) (
  input  logic                clk_25mhz,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    level_in,
  input  logic                level_valid,
  output logic                level_ready,
  input  logic [CHANNELS-1:0] chan_mask,
  output logic                period_start,
  output logic [CHANNELS-1:0] led
);

  // A single-bit prescaler is kept for PRESCALE=1; it simply never leaves 0.
  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0]   PsMax    = PsW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] PhaseMax = '1;

  logic [PsW-1:0]      prescaler_q, prescaler_d;
  logic [WIDTH-1:0]    phase_q, phase_d;
  logic [WIDTH-1:0]    duty_q, duty_d;
  logic [WIDTH-1:0]    pending_q, pending_d;
  logic                pending_full_q, pending_full_d;
  logic [CHANNELS-1:0] led_q, led_d;
  logic                period_start_q, period_start_d;

  logic tick;
  logic boundary;
  logic accept;
  logic pwm_on;

  assign tick        = (prescaler_q == PsMax);
  assign boundary    = tick && (phase_q == PhaseMax);
  assign level_ready = !pending_full_q;
  assign accept      = level_valid && level_ready;

  // Slot timebase: prescaler wraps at PRESCALE-1, phase advances once per slot.
  always_comb begin
    prescaler_d = prescaler_q + 1'b1;
    phase_d     = phase_q;
    if (tick) begin
      prescaler_d = '0;
      phase_d     = phase_q + 1'b1;
    end
  end

  // One-deep level buffer; the active duty is swapped only at a boundary.
  // Accept and apply cannot coincide because ready is low while full.
  always_comb begin
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    duty_d         = duty_q;
    if (accept) begin
      pending_d      = level_in;
      pending_full_d = 1'b1;
    end else if (boundary && pending_full_q) begin
      duty_d         = pending_q;
      pending_full_d = 1'b0;
    end
  end

  // Output compare: a slot is high while the phase is below the active duty.
  always_comb begin
    pwm_on         = (phase_q < duty_q);
    led_d          = chan_mask & {CHANNELS{pwm_on}};
    period_start_d = (phase_q == '0) && (prescaler_q == '0);
  end

  // State registers; async assert, release is synchronised outside this block.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q    <= '0;
      phase_q        <= '0;
      duty_q         <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      led_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      prescaler_q    <= prescaler_d;
      phase_q        <= phase_d;
      duty_q         <= duty_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      led_q          <= led_d;
      period_start_q <= period_start_d;
    end
  end

  assign led          = led_q;
  assign period_start = period_start_q;

endmodule
